// File: rtl/tmr_spike_rate_decoder.sv
// Windowed firing-rate and lane-health decoder for a TMR spiking neuron.
// Publishes one result per WINDOW sampled timesteps over a valid/ready handshake.
module tmr_spike_rate_decoder #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             step_en,
  input  logic             spike_in1,
  input  logic             spike_in2,
  input  logic             spike_in3,
  input  logic             spike_voted,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rate_out,
  output logic [ERR_W-1:0] mis_cnt1,
  output logic [ERR_W-1:0] mis_cnt2,
  output logic [ERR_W-1:0] mis_cnt3,
  output logic             vote_err,
  output logic             overrun,
  input  logic             clr_overrun
);
  localparam int                STEP_W    = $clog2(WINDOW);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;

  logic [STEP_W-1:0] step_cnt;
  logic [CNT_W-1:0]  rate_acc, rate_nxt;
  logic [ERR_W-1:0]  mis_acc [3];
  logic [ERR_W-1:0]  mis_nxt [3];
  logic              verr_acc, verr_nxt;
  logic [2:0]        lanes;
  logic              maj, sample, win_done, accept;

  assign lanes    = {spike_in3, spike_in2, spike_in1};
  assign maj      = (spike_in1 & spike_in2) | (spike_in2 & spike_in3) | (spike_in1 & spike_in3);
  assign sample   = (state == ACCUM) && enable && step_en;
  assign win_done = sample && (step_cnt == LAST_STEP);
  assign accept   = out_valid && out_ready;

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable)  state_nxt = ACCUM;
      ACCUM: if (!enable) state_nxt = IDLE;
    endcase
  end

  // Accumulators including the current step; this is also what a completing window publishes.
  always_comb begin
    rate_nxt = rate_acc + CNT_W'(spike_voted);
    verr_nxt = verr_acc | (spike_voted ^ maj);
    for (int i = 0; i < 3; i++) begin
      mis_nxt[i] = mis_acc[i];
      if ((lanes[i] ^ maj) && (mis_acc[i] != ERR_MAX)) mis_nxt[i] = mis_acc[i] + ERR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the three-entry mismatch array is plain flop state, so it is reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      rate_acc <= '0;
      verr_acc <= 1'b0;
      for (int i = 0; i < 3; i++) mis_acc[i] <= '0;
    end else if (state != ACCUM || !enable || win_done) begin
      // Idle, disabled mid-window, or window just published: start the next window clean.
      step_cnt <= '0;
      rate_acc <= '0;
      verr_acc <= 1'b0;
      for (int i = 0; i < 3; i++) mis_acc[i] <= '0;
    end else if (sample) begin
      step_cnt <= step_cnt + STEP_W'(1);
      rate_acc <= rate_nxt;
      verr_acc <= verr_nxt;
      for (int i = 0; i < 3; i++) mis_acc[i] <= mis_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out <= '0;
      mis_cnt1 <= '0;
      mis_cnt2 <= '0;
      mis_cnt3 <= '0;
      vote_err <= 1'b0;
    end else if (win_done) begin
      rate_out <= rate_nxt;
      mis_cnt1 <= mis_nxt[0];
      mis_cnt2 <= mis_nxt[1];
      mis_cnt3 <= mis_nxt[2];
      vote_err <= verr_nxt;
    end
  end

  // A new result wins over acceptance; overwriting an unread result flags overrun, set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (win_done)    out_valid <= 1'b1;
      else if (accept) out_valid <= 1'b0;

      if (win_done && out_valid && !out_ready) overrun <= 1'b1;
      else if (clr_overrun)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmr_spike_rate_decoder.sv
// Self-checking bench for tmr_spike_rate_decoder: per-cycle comparison against a window-level
// model built from a queue of sampled steps, plus hand-computed literal expectations.
module tb_tmr_spike_rate_decoder;
  localparam int WINDOW  = 16;
  localparam int CNT_W   = 5;
  localparam int ERR_W   = 4;
  localparam int ERR_SAT = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, step_en = 1'b0;
  logic spike_in1 = 1'b0, spike_in2 = 1'b0, spike_in3 = 1'b0, spike_voted = 1'b0;
  logic out_ready = 1'b0, clr_overrun = 1'b0;
  logic out_valid, vote_err, overrun;
  logic [CNT_W-1:0] rate_out;
  logic [ERR_W-1:0] mis_cnt1, mis_cnt2, mis_cnt3;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tmr_spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_en(step_en),
    .spike_in1(spike_in1), .spike_in2(spike_in2), .spike_in3(spike_in3),
    .spike_voted(spike_voted), .out_valid(out_valid), .out_ready(out_ready),
    .rate_out(rate_out), .mis_cnt1(mis_cnt1), .mis_cnt2(mis_cnt2), .mis_cnt3(mis_cnt3),
    .vote_err(vote_err), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- window-level model ----------------
  bit       m_accum;
  bit [3:0] win_q[$];   // each entry {voted, s3, s2, s1}
  bit       exp_valid, exp_verr, exp_ovr;
  int       exp_rate, exp_m1, exp_m2, exp_m3;

  always @(posedge clk or negedge rst_n) begin : model
    bit done, maj_b, ve;
    bit [3:0] e;
    int r, c1, c2, c3;
    if (!rst_n) begin
      m_accum = 1'b0; win_q.delete();
      exp_valid = 1'b0; exp_verr = 1'b0; exp_ovr = 1'b0;
      exp_rate = 0; exp_m1 = 0; exp_m2 = 0; exp_m3 = 0;
    end else begin
      done = 1'b0;
      if (m_accum && enable && step_en) begin
        win_q.push_back({spike_voted, spike_in3, spike_in2, spike_in1});
        if (win_q.size() == WINDOW) done = 1'b1;
      end
      if (m_accum && !enable) win_q.delete();
      if (done) begin
        r = 0; c1 = 0; c2 = 0; c3 = 0; ve = 1'b0;
        foreach (win_q[k]) begin
          e = win_q[k];
          maj_b = (int'(e[0]) + int'(e[1]) + int'(e[2])) >= 2;
          r += int'(e[3]);
          if (e[0] != maj_b) c1++;
          if (e[1] != maj_b) c2++;
          if (e[2] != maj_b) c3++;
          if (e[3] != maj_b) ve = 1'b1;
        end
        win_q.delete();
        if (exp_valid && !out_ready) exp_ovr = 1'b1;
        else if (clr_overrun)        exp_ovr = 1'b0;
        exp_valid = 1'b1;
        exp_rate = r;
        exp_m1 = (c1 > ERR_SAT) ? ERR_SAT : c1;
        exp_m2 = (c2 > ERR_SAT) ? ERR_SAT : c2;
        exp_m3 = (c3 > ERR_SAT) ? ERR_SAT : c3;
        exp_verr = ve;
      end else begin
        if (exp_valid && out_ready) exp_valid = 1'b0;
        if (clr_overrun)            exp_ovr = 1'b0;
      end
      m_accum = enable;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cyc_valid",   out_valid, exp_valid);
      check("cyc_rate",    rate_out,  exp_rate);
      check("cyc_mis1",    mis_cnt1,  exp_m1);
      check("cyc_mis2",    mis_cnt2,  exp_m2);
      check("cyc_mis3",    mis_cnt3,  exp_m3);
      check("cyc_voteerr", vote_err,  exp_verr);
      check("cyc_overrun", overrun,   exp_ovr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic se, input logic [3:0] sp);
    step_en = se;
    {spike_voted, spike_in3, spike_in2, spike_in1} = sp;
    @(negedge clk);
  endtask

  task automatic expect_out(input string pfx, input logic v, input int r, input int m1,
                            input int m2, input int m3, input logic ve, input logic ov);
    check({pfx, "_valid"},   out_valid, v);
    check({pfx, "_rate"},    rate_out,  r);
    check({pfx, "_mis1"},    mis_cnt1,  m1);
    check({pfx, "_mis2"},    mis_cnt2,  m2);
    check({pfx, "_mis3"},    mis_cnt3,  m3);
    check({pfx, "_voteerr"}, vote_err,  ve);
    check({pfx, "_overrun"}, overrun,   ov);
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    tick(1'b0, 4'b0000);
    out_ready = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    expect_out("reset", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    release_reset();
    chk_en = 1'b1;

    // All lanes and voted high; the first step lands in IDLE and is ignored.
    enable = 1'b1;
    tick(1'b1, 4'b1111);
    for (int i = 0; i < WINDOW - 1; i++) tick(1'b1, 4'b1111);
    check("allone_pre_valid", out_valid, 1'b0);
    tick(1'b1, 4'b1111);
    expect_out("allone", 1'b1, 16, 0, 0, 0, 1'b0, 1'b0);
    accept_result();
    check("allone_accepted", out_valid, 1'b0);

    // Lane 2 stuck at 0; lanes 1/3 and voted fire on 10 of 16 steps.
    for (int i = 0; i < WINDOW; i++) tick(1'b1, (i % 8 < 5) ? 4'b1101 : 4'b0000);
    expect_out("lane2stuck", 1'b1, 10, 0, 10, 0, 1'b0, 1'b0);
    accept_result();

    // Voter drops one step where all lanes agree on 1.
    for (int i = 0; i < WINDOW; i++) tick(1'b1, (i == 3) ? 4'b0111 : 4'b1111);
    expect_out("voterr", 1'b1, 15, 0, 0, 0, 1'b1, 1'b0);
    accept_result();

    // Two windows without acceptance.
    for (int i = 0; i < WINDOW; i++) tick(1'b1, 4'b0000);
    expect_out("ovr_a", 1'b1, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < WINDOW; i++) begin
      tick(1'b1, (i < 4) ? 4'b1111 : 4'b0000);
      if (i == 7) check("ovr_hold_rate", rate_out, 0);
    end
    expect_out("ovr_b", 1'b1, 4, 0, 0, 0, 1'b0, 1'b1);
    clr_overrun = 1'b1;
    tick(1'b0, 4'b0000);
    clr_overrun = 1'b0;
    expect_out("ovr_clr", 1'b1, 4, 0, 0, 0, 1'b0, 1'b0);

    // Overwrite while clr_overrun is asserted on the same edge: set wins.
    for (int i = 0; i < WINDOW; i++) begin
      if (i == WINDOW - 1) clr_overrun = 1'b1;
      tick(1'b1, (i < 2) ? 4'b1111 : 4'b0000);
    end
    clr_overrun = 1'b0;
    expect_out("ovr_setwins", 1'b1, 2, 0, 0, 0, 1'b0, 1'b1);

    // Window completes on the accepting edge: valid stays, overrun untouched.
    for (int i = 0; i < WINDOW; i++) begin
      if (i == WINDOW - 1) out_ready = 1'b1;
      tick(1'b1, 4'b1111);
    end
    out_ready = 1'b0;
    expect_out("acc_same_edge", 1'b1, 16, 0, 0, 0, 1'b0, 1'b1);
    out_ready = 1'b1;
    clr_overrun = 1'b1;
    tick(1'b0, 4'b0000);
    out_ready = 1'b0;
    clr_overrun = 1'b0;
    check("drain_valid", out_valid, 1'b0);
    check("drain_overrun", overrun, 1'b0);

    // Lane 3 opposes the other lanes every step: saturates at 15.
    for (int i = 0; i < WINDOW; i++) tick(1'b1, (i % 2 == 0) ? 4'b1011 : 4'b0100);
    expect_out("lane3sat", 1'b1, 8, 0, 0, ERR_SAT, 1'b0, 1'b0);
    accept_result();

    // Enable drops after 8 steps: partial window discarded, no result.
    for (int i = 0; i < 8; i++) tick(1'b1, 4'b1111);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 4'b1111);
    expect_out("disable", 1'b0, 8, 0, 0, ERR_SAT, 1'b0, 1'b0);
    enable = 1'b1;
    tick(1'b0, 4'b0000);
    for (int i = 0; i < WINDOW; i++) tick(1'b1, (i < 5) ? 4'b1111 : 4'b0000);
    expect_out("reenable", 1'b1, 5, 0, 0, 0, 1'b0, 1'b0);

    // Reset after 5 steps of a window while a result is pending.
    for (int i = 0; i < 5; i++) tick(1'b1, 4'b1111);
    step_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_out("midreset", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    release_reset();
    tick(1'b0, 4'b0000);
    for (int i = 0; i < WINDOW; i++) begin
      tick(1'b1, (i < 7) ? 4'b1111 : 4'b0000);
      if (i == WINDOW - 6) check("postreset_no_early", out_valid, 1'b0);
    end
    expect_out("postreset", 1'b1, 7, 0, 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
